memory_cycle: RTL and testbench

Memory stage of the 32-bit RISC-V pipeline core. Takes the EX/MEM-stage operands and performs RV32I loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) against an internal little-endian data memory. Produces the registered MEM/WB signals (`ALU_ResultW`, `ReadDataW`, `PCPlus4W`, `ResultSrcW`, `RegWriteW`, `RdW`) that `writeback_cycle` consumes to select `ResultW`. Holds the MEM/WB register under stall, clears it under flush, and flags misaligned or illegal accesses.

---
 rtl/memory_cycle_if.sv | 36 +++
 rtl/memory_cycle.sv | 131 +++++++++++++
 tb/tb_memory_cycle.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/memory_cycle_if.sv
// MEM-stage operands in, MEM/WB register contents out, grouped as one bundle.
// The master drives the M-stage side and the slave (memory_cycle) drives W.
interface memory_cycle_if;
  logic        RegWriteM;
  logic        MemWriteM;
  logic        ResultSrcM;
  logic [2:0]  funct3M;
  logic [4:0]  RdM;
  logic [31:0] ALU_ResultM;
  logic [31:0] WriteDataM;
  logic [31:0] PCPlus4M;
  logic        StallW;
  logic        FlushW;

  logic        RegWriteW;
  logic        ResultSrcW;
  logic [4:0]  RdW;
  logic [31:0] ALU_ResultW;
  logic [31:0] ReadDataW;
  logic [31:0] PCPlus4W;
  logic        MisalignW;

  modport master (
    output RegWriteM, MemWriteM, ResultSrcM, funct3M, RdM,
           ALU_ResultM, WriteDataM, PCPlus4M, StallW, FlushW,
    input  RegWriteW, ResultSrcW, RdW, ALU_ResultW, ReadDataW,
           PCPlus4W, MisalignW
  );

  modport slave (
    input  RegWriteM, MemWriteM, ResultSrcM, funct3M, RdM,
           ALU_ResultM, WriteDataM, PCPlus4M, StallW, FlushW,
    output RegWriteW, ResultSrcW, RdW, ALU_ResultW, ReadDataW,
           PCPlus4W, MisalignW
  );
endinterface

// File: rtl/memory_cycle.sv
// RV32I memory stage: byte-lane data memory, load extension, bad-access
// detection and the MEM/WB pipeline register with stall/flush control.
module memory_cycle #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input logic           clk,
  input logic           rst,
  memory_cycle_if.slave bus
);

  logic [31:0]       mem_r [DEPTH_WORDS];
  logic [ADDR_W-1:0] word_idx_s;
  logic [1:0]        off_s;
  logic              active_s;
  logic              illegal_s;
  logic              misalign_s;
  logic              bad_s;
  logic              store_en_s;
  logic [3:0]        byte_en_s;
  logic [31:0]       wr_word_s;
  logic [31:0]       rd_word_s;
  logic [31:0]       load_data_s;

  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b010:  res = word;
      3'b100:  res = {24'h000000, b};
      3'b101:  res = {16'h0000, h};
      default: res = 32'h0000_0000;
    endcase
    extend_load = res;
  endfunction

  assign word_idx_s = bus.ALU_ResultM[ADDR_W+1:2];
  assign off_s      = bus.ALU_ResultM[1:0];
  assign rd_word_s  = mem_r[word_idx_s];

  // Classify the access and build lane enables and replicated store data.
  always_comb begin
    active_s   = bus.MemWriteM | bus.ResultSrcM;
    illegal_s  = 1'b0;
    misalign_s = 1'b0;
    byte_en_s  = 4'b0000;
    wr_word_s  = bus.WriteDataM;
    case (bus.funct3M)
      3'b011, 3'b110, 3'b111: illegal_s = 1'b1;
      3'b100, 3'b101:         illegal_s = bus.MemWriteM;
      default:                illegal_s = 1'b0;
    endcase
    case (bus.funct3M[1:0])
      2'b00: begin
        misalign_s = 1'b0;
        byte_en_s  = 4'b0001 << off_s;
        wr_word_s  = {4{bus.WriteDataM[7:0]}};
      end
      2'b01: begin
        misalign_s = off_s[0];
        byte_en_s  = off_s[1] ? 4'b1100 : 4'b0011;
        wr_word_s  = {2{bus.WriteDataM[15:0]}};
      end
      2'b10: begin
        misalign_s = (off_s != 2'b00);
        byte_en_s  = 4'b1111;
        wr_word_s  = bus.WriteDataM;
      end
      default: begin
        misalign_s = 1'b0;
        byte_en_s  = 4'b0000;
        wr_word_s  = bus.WriteDataM;
      end
    endcase
    bad_s      = active_s & (illegal_s | misalign_s);
    store_en_s = bus.MemWriteM & ~bad_s & ~bus.StallW & ~bus.FlushW & ~rst;
    if (bus.ResultSrcM && !bad_s) begin
      load_data_s = extend_load(rd_word_s, off_s, bus.funct3M);
    end else begin
      load_data_s = 32'h0000_0000;
    end
  end

  // Byte-lane store into the data memory; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (store_en_s) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en_s[i]) begin
          mem_r[word_idx_s][8*i +: 8] <= wr_word_s[8*i +: 8];
        end
      end
    end
  end

  // MEM/WB register: reset beats flush beats stall.
  always_ff @(posedge clk) begin
    if (rst || bus.FlushW) begin
      bus.RegWriteW   <= 1'b0;
      bus.ResultSrcW  <= 1'b0;
      bus.RdW         <= 5'd0;
      bus.ALU_ResultW <= 32'h0000_0000;
      bus.ReadDataW   <= 32'h0000_0000;
      bus.PCPlus4W    <= 32'h0000_0000;
      bus.MisalignW   <= 1'b0;
    end else if (!bus.StallW) begin
      bus.RegWriteW   <= bus.RegWriteM & ~bad_s;
      bus.ResultSrcW  <= bus.ResultSrcM;
      bus.RdW         <= bus.RdM;
      bus.ALU_ResultW <= bus.ALU_ResultM;
      bus.ReadDataW   <= load_data_s;
      bus.PCPlus4W    <= bus.PCPlus4M;
      bus.MisalignW   <= bad_s;
    end else begin
      bus.RegWriteW   <= bus.RegWriteW;
      bus.ResultSrcW  <= bus.ResultSrcW;
      bus.RdW         <= bus.RdW;
      bus.ALU_ResultW <= bus.ALU_ResultW;
      bus.ReadDataW   <= bus.ReadDataW;
      bus.PCPlus4W    <= bus.PCPlus4W;
      bus.MisalignW   <= bus.MisalignW;
    end
  end

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle: loads/stores, extension, bad accesses,
// stall/flush/reset priority and address wrap, with hand-computed expectations.
module tb_memory_cycle;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  memory_cycle_if bus ();

  memory_cycle #(.DEPTH_WORDS(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic mw, input logic rs,
                       input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] pc, input logic st, input logic fl);
    bus.RegWriteM   = rw;
    bus.MemWriteM   = mw;
    bus.ResultSrcM  = rs;
    bus.funct3M     = f3;
    bus.RdM         = rd;
    bus.ALU_ResultM = addr;
    bus.WriteDataM  = wd;
    bus.PCPlus4M    = pc;
    bus.StallW      = st;
    bus.FlushW      = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    drive(1'b0, 1'b1, 1'b0, f3, 5'd0, addr, wd, 32'h0000_0100, 1'b0, 1'b0);
    tick();
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
    drive(1'b1, 1'b0, 1'b1, f3, rd, addr, 32'h0000_0000, 32'h0000_1000, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Reset with a word store presented: outputs clear, store suppressed.
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 3'b010, 5'd1, 32'h0, 32'hDEAD_BEEF, 32'h4, 1'b0, 1'b0);
    tick();
    chk("rst_regwrite",  {31'd0, bus.RegWriteW},  32'h0);
    chk("rst_resultsrc", {31'd0, bus.ResultSrcW}, 32'h0);
    chk("rst_rd",        {27'd0, bus.RdW},        32'h0);
    chk("rst_alu",       bus.ALU_ResultW,         32'h0);
    chk("rst_rdata",     bus.ReadDataW,           32'h0);
    chk("rst_pc",        bus.PCPlus4W,            32'h0);
    chk("rst_misalign",  {31'd0, bus.MisalignW},  32'h0);
    rst = 1'b0;

    store(3'b010, 32'h0, 32'h1111_1111);
    chk("sw0_regwrite", {31'd0, bus.RegWriteW}, 32'h0);
    chk("sw0_misalign", {31'd0, bus.MisalignW}, 32'h0);
    load(3'b010, 32'h0, 5'd5);
    chk("lw0_data", bus.ReadDataW, 32'h1111_1111);
    chk("lw0_rd",   {27'd0, bus.RdW}, 32'd5);

    // Word store and all load widths against lanes 01,7F,FF,80.
    store(3'b010, 32'h10, 32'h80FF_7F01);
    load(3'b010, 32'h10, 5'd6);
    chk("lw10_data",      bus.ReadDataW, 32'h80FF_7F01);
    chk("lw10_regwrite",  {31'd0, bus.RegWriteW},  32'h1);
    chk("lw10_resultsrc", {31'd0, bus.ResultSrcW}, 32'h1);
    load(3'b000, 32'h13, 5'd6);
    chk("lb13", bus.ReadDataW, 32'hFFFF_FF80);
    load(3'b100, 32'h13, 5'd6);
    chk("lbu13", bus.ReadDataW, 32'h0000_0080);
    load(3'b001, 32'h12, 5'd6);
    chk("lh12", bus.ReadDataW, 32'hFFFF_80FF);
    load(3'b101, 32'h10, 5'd6);
    chk("lhu10", bus.ReadDataW, 32'h0000_7F01);

    // Partial stores: byte into lane 1, half into lanes 2-3.
    store(3'b010, 32'h20, 32'h0);
    store(3'b000, 32'h21, 32'h1234_56AA);
    store(3'b001, 32'h22, 32'hABCD_1234);
    load(3'b010, 32'h20, 5'd2);
    chk("partial_lw20", bus.ReadDataW, 32'h1234_AA00);

    load(3'b001, 32'h21, 5'd2);
    chk("mis_lh_flag",     {31'd0, bus.MisalignW},  32'h1);
    chk("mis_lh_regwrite", {31'd0, bus.RegWriteW},  32'h0);
    chk("mis_lh_data",     bus.ReadDataW,           32'h0);
    chk("mis_lh_alu",      bus.ALU_ResultW,         32'h21);
    store(3'b010, 32'h22, 32'hFFFF_FFFF);
    chk("mis_sw_flag", {31'd0, bus.MisalignW}, 32'h1);
    load(3'b010, 32'h20, 5'd2);
    chk("mis_sw_unchanged", bus.ReadDataW, 32'h1234_AA00);
    chk("mis_clear",        {31'd0, bus.MisalignW}, 32'h0);

    // Stall: W frozen, store commits only after release.
    store(3'b010, 32'h30, 32'h0);
    store(3'b010, 32'h34, 32'h0);
    load(3'b010, 32'h20, 5'd9);
    drive(1'b0, 1'b1, 1'b0, 3'b010, 5'd0, 32'h30, 32'h5555_AAAA, 32'h200, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_alu",   bus.ALU_ResultW, 32'h20);
      chk("stall_rdata", bus.ReadDataW,   32'h1234_AA00);
      chk("stall_rd",    {27'd0, bus.RdW}, 32'd9);
    end
    bus.StallW = 1'b0;
    tick();
    chk("release_alu",   bus.ALU_ResultW, 32'h30);
    chk("release_rdata", bus.ReadDataW,   32'h0);
    load(3'b010, 32'h30, 5'd3);
    chk("release_lw30", bus.ReadDataW, 32'h5555_AAAA);

    drive(1'b0, 1'b1, 1'b0, 3'b010, 5'd0, 32'h34, 32'hFFFF_FFFF, 32'h200, 1'b1, 1'b0);
    tick();
    tick();
    load(3'b010, 32'h34, 5'd3);
    chk("stall_suppress_lw34", bus.ReadDataW, 32'h0);

    // Flush alone, then flush together with stall.
    load(3'b010, 32'h30, 5'd3);
    drive(1'b1, 1'b1, 1'b0, 3'b010, 5'd4, 32'h30, 32'h7777_7777, 32'h300, 1'b0, 1'b1);
    tick();
    chk("flush_regwrite", {31'd0, bus.RegWriteW}, 32'h0);
    chk("flush_alu",      bus.ALU_ResultW,        32'h0);
    chk("flush_rd",       {27'd0, bus.RdW},       32'h0);
    load(3'b010, 32'h30, 5'd3);
    chk("flush_lw30", bus.ReadDataW, 32'h5555_AAAA);
    drive(1'b1, 1'b1, 1'b0, 3'b010, 5'd4, 32'h30, 32'h9999_9999, 32'h300, 1'b1, 1'b1);
    tick();
    chk("stflush_resultsrc", {31'd0, bus.ResultSrcW}, 32'h0);
    chk("stflush_rdata",     bus.ReadDataW,           32'h0);
    chk("stflush_pc",        bus.PCPlus4W,            32'h0);
    load(3'b010, 32'h30, 5'd3);
    chk("stflush_lw30", bus.ReadDataW, 32'h5555_AAAA);

    // Reset while stalled clears everything.
    drive(1'b1, 1'b0, 1'b0, 3'b000, 5'd8, 32'h44, 32'h0, 32'h400, 1'b1, 1'b0);
    tick();
    chk("prerst_hold", bus.ReadDataW, 32'h5555_AAAA);
    rst = 1'b1;
    tick();
    chk("rststall_alu",      bus.ALU_ResultW,        32'h0);
    chk("rststall_rdata",    bus.ReadDataW,          32'h0);
    chk("rststall_regwrite", {31'd0, bus.RegWriteW}, 32'h0);
    rst = 1'b0;

    // Address wrap at 4 KiB and plain ALU pass-through.
    store(3'b010, 32'h1004, 32'hCAFE_F00D);
    load(3'b010, 32'h4, 5'd10);
    chk("wrap_lw4",  bus.ReadDataW,   32'hCAFE_F00D);
    chk("wrap_alu4", bus.ALU_ResultW, 32'h4);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 5'd7, 32'h1234, 32'hFFFF_FFFF, 32'h2008, 1'b0, 1'b0);
    tick();
    chk("alu_result",    bus.ALU_ResultW,         32'h1234);
    chk("alu_pc",        bus.PCPlus4W,            32'h2008);
    chk("alu_rd",        {27'd0, bus.RdW},        32'd7);
    chk("alu_rdata",     bus.ReadDataW,           32'h0);
    chk("alu_regwrite",  {31'd0, bus.RegWriteW},  32'h1);
    chk("alu_resultsrc", {31'd0, bus.ResultSrcW}, 32'h0);

    // Illegal funct3 encodings.
    load(3'b011, 32'h10, 5'd11);
    chk("ill_ld_flag", {31'd0, bus.MisalignW}, 32'h1);
    chk("ill_ld_data", bus.ReadDataW,          32'h0);
    store(3'b100, 32'h10, 32'h0);
    chk("ill_st_flag", {31'd0, bus.MisalignW}, 32'h1);
    load(3'b010, 32'h10, 5'd11);
    chk("ill_st_unchanged", bus.ReadDataW, 32'h80FF_7F01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
